// File: rtl/mmio_controller.sv
// MMIO controller for the 0xF000_0000 region: req/ack bus FSM, HEX/LEDR registers,
// synchronised SW and debounced KEY with W1C press flags. Define MMIO_KEY_IRQ_EN for kmask/irq.

module mmio_key_debounce #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic pressed,
  input  logic clr,
  output logic state,
  output logic kedge
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          flip;
  logic          rise;

  assign flip = (pressed != state) && (cnt == LAST);
  assign rise = flip && !state;

  // Counter clears on any agreement, so it never runs past LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (pressed != state) begin
      if (flip) begin
        state <= ~state;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // A new press beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) kedge <= 1'b0;
    else        kedge <= rise | (kedge & ~clr);
  end
endmodule

module mmio_controller #(
  parameter int              DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_HEX       = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR      = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_KEY       = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW        = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KSTAT     = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_KMASK     = 32'hF0000114,
  parameter int              DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  input  logic             we,
  input  logic             re,
  output logic             hit,
  output logic [DBITS-1:0] rdata,
  output logic             ack,
  input  logic [3:0]       key_in,
  input  logic [9:0]       sw_in,
  output logic [15:0]      hex_out,
  output logic [9:0]       ledr_out
`ifdef MMIO_KEY_IRQ_EN
  ,output logic            irq
`endif
);
  localparam int NUM_KEYS = 4;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_ACK} state_t;

  state_t              state, state_nxt;
  logic                wr_en, rd_latch;
  logic [DBITS-1:0]    rd_mux;
  logic [NUM_KEYS-1:0] key_s1, key_s2, key_pressed;
  logic [9:0]          sw_s1, sw_sync;
  logic [NUM_KEYS-1:0] kstate, kedge, kclr;
  logic                unused_wdata;

  assign unused_wdata = ^wdata[DBITS-1:16];
  assign hit = (addr[DBITS-1 -: 4] == 4'hF);
  assign ack = (state == S_ACK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Writes commit on the IDLE edge; reads take one extra cycle in RD to latch.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    rd_latch  = 1'b0;
    case (state)
      S_IDLE: begin
        if (hit && we) begin
          wr_en     = 1'b1;
          state_nxt = S_ACK;
        end else if (hit && re) begin
          state_nxt = S_RD;
        end
      end
      S_RD: begin
        rd_latch  = 1'b1;
        state_nxt = S_ACK;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1  <= '0;
      key_s2  <= '0;
      sw_s1   <= '0;
      sw_sync <= '0;
    end else begin
      key_s1  <= key_in;
      key_s2  <= key_s1;
      sw_s1   <= sw_in;
      sw_sync <= sw_s1;
    end
  end

  // Board keys are active-low; invert after synchronising so pressed=1.
  assign key_pressed = ~key_s2;
  assign kclr = (wr_en && addr == ADDR_KSTAT) ? wdata[NUM_KEYS-1:0] : '0;

  mmio_key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_KEYS-1:0] (
    .clk    (clk),
    .reset  (reset),
    .pressed(key_pressed),
    .clr    (kclr),
    .state  (kstate),
    .kedge  (kedge)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_out  <= '0;
      ledr_out <= '0;
    end else if (wr_en) begin
      if (addr == ADDR_HEX)  hex_out  <= wdata[15:0];
      if (addr == ADDR_LEDR) ledr_out <= wdata[9:0];
    end
  end

`ifdef MMIO_KEY_IRQ_EN
  logic [NUM_KEYS-1:0] kmask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kmask <= '0;
      irq   <= 1'b0;
    end else begin
      if (wr_en && addr == ADDR_KMASK) kmask <= wdata[NUM_KEYS-1:0];
      irq <= |(kedge & kmask);
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_HEX:   rd_mux = {{(DBITS-16){1'b0}}, hex_out};
      ADDR_LEDR:  rd_mux = {{(DBITS-10){1'b0}}, ledr_out};
      ADDR_KEY:   rd_mux = {{(DBITS-NUM_KEYS){1'b0}}, kstate};
      ADDR_SW:    rd_mux = {{(DBITS-10){1'b0}}, sw_sync};
      ADDR_KSTAT: rd_mux = {{(DBITS-NUM_KEYS){1'b0}}, kedge};
`ifdef MMIO_KEY_IRQ_EN
      ADDR_KMASK: rd_mux = {{(DBITS-NUM_KEYS){1'b0}}, kmask};
`endif
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        rdata <= '0;
    else if (rd_latch) rdata <= rd_mux;
  end
endmodule
